intersection_phase_scheduler: RTL and testbench
===============================================

INTERSECTION_PHASE_SCHEDULER -- requirements
Module: intersection_phase_scheduler

Interface
REQ-001 Parameter MIN_GREEN, 4: minimum green cycles per direction (1..255).
REQ-002 Parameter MAX_GREEN, 16: green cycles after which a waiting conflicting request forces change (MIN_GREEN..255).
REQ-003 Parameter YELLOW_T, 3: yellow duration in cycles (1..255).
REQ-004 Parameter ALLRED_T, 2: all-red clearance duration in cycles (1..255).
REQ-005 Parameter WALK_T, 6: pedestrian walk duration in cycles (1..255).
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 Ta, Tb  input  1 each  traffic present on street A / street B.
REQ-009 ped_req  input  1  pedestrian request, level or pulse.
REQ-010 Ra, Ya, Ga, Rb, Yb, Gb  output  1 each  lamp drives, decoded from state only (Moore).
REQ-011 walk  output  1  high throughout walk phase.
REQ-012 ped_ack  output  1  one-cycle pulse in the first cycle of walk phase.
REQ-013 phase  output  3  current state encoding.

Function
REQ-014 States SHALL be AG=0, AY=1, AR1=2, BG=3, BY=4, AR2=5, PW=6; code 7 SHALL recover to AR1 next cycle.
REQ-015 Phase timer cnt (8 bits) SHALL clear on every state change, else increment, saturating at 255.
REQ-016 AG -> AY when (cnt >= MIN_GREEN-1 and !Ta and (Tb or ped_pend)) or (cnt >= MAX_GREEN-1 and (Tb or ped_pend)); otherwise AG holds indefinitely.
REQ-017 BG -> BY by the same rule with Ta/Tb swapped.
REQ-018 AY -> AR1 and BY -> AR2 when cnt == YELLOW_T-1.
REQ-019 AR1/AR2 exit when cnt == ALLRED_T-1: to PW if ped_pend, else AR1 -> BG, AR2 -> AG.
REQ-020 Register next_dir SHALL record the green due after an all-red (B from AR1, A from AR2); PW -> BG or AG per next_dir when cnt == WALK_T-1.
REQ-021 ped_pend SHALL set on ped_req and clear on PW entry; simultaneous set and clear leaves it set (a request during walk earns a further walk).
REQ-022 Lamps: AG: Ga,Rb; AY: Ya,Rb; BG: Ra,Gb; BY: Ra,Yb; AR1, AR2, PW: Ra,Rb; exactly one lamp per street SHALL be lit every cycle.
REQ-023 A green SHALL never coincide with any non-red lamp on the other street, including in recovery from illegal state.

Reset
REQ-024 Reset SHALL force state AG, cnt 0, ped_pend 0, next_dir B, hence Ga=1, Rb=1, all others 0, walk=0, ped_ack=0, phase=0.
REQ-025 Reset asserted mid-phase SHALL take effect immediately (asynchronously), discarding pending requests.

Configuration
REQ-026 Macro INTERSECTION_PED_EN defined: pedestrian logic per REQ-019..021 present.
REQ-027 Macro absent: ped_pend tied 0, ped_req ignored, PW unreachable (code 6 treated as illegal, REQ-014), walk and ped_ack tied 0; ports retained.

Structure
REQ-028 Package traffic_pkg SHALL hold state encodings and default timing constants, shared with traffic_light_controller benches.
REQ-029 One sub-module phase_timer SHALL implement cnt (clear, increment, saturate) and expose cnt to the FSM.

Verification (defaults)
REQ-030 Reset, Ta=1, Tb=0 for 100 cycles -> AG held, Ga=1, Rb=1 throughout.
REQ-031 Ta=0, Tb=1 from reset release -> AY entered at cycle 4, AR1 at 7, BG at 9.
REQ-032 Ta=1, Tb=1 held -> AG lasts 16 cycles, BG lasts 16 cycles, alternating with 3 yellow + 2 all-red between.
REQ-033 PED_EN, ped_req pulse in AG with Tb=0 -> AY at cycle 4, PW after AR1, ped_ack one cycle, walk 6 cycles, then BG.
REQ-034 ped_req held during PW -> second PW after next yellow/all-red.
REQ-035 Reset asserted in BY -> outputs at reset values before next clock edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared state encodings, lamp decode and default timing for the intersection
// controllers and their benches.
package traffic_pkg;

    localparam int CNT_W = 8;

    localparam int DEF_MIN_GREEN = 4;
    localparam int DEF_MAX_GREEN = 16;
    localparam int DEF_YELLOW_T  = 3;
    localparam int DEF_ALLRED_T  = 2;
    localparam int DEF_WALK_T    = 6;

    typedef enum logic [2:0] {
        ST_AG  = 3'd0,
        ST_AY  = 3'd1,
        ST_AR1 = 3'd2,
        ST_BG  = 3'd3,
        ST_BY  = 3'd4,
        ST_AR2 = 3'd5,
        ST_PW  = 3'd6,
        ST_BAD = 3'd7
    } state_t;

    typedef enum logic {
        DIR_A = 1'b0,
        DIR_B = 1'b1
    } dir_t;

    typedef struct packed {
        logic ra;
        logic ya;
        logic ga;
        logic rb;
        logic yb;
        logic gb;
    } lamps_t;

    // Anything other than a green or yellow phase shows red both ways,
    // so an illegal code can never light a conflicting lamp.
    function automatic lamps_t lamps_for(state_t s);
        lamps_t l;
        l = '0;
        case (s)
            ST_AG: begin
                l.ga = 1'b1;
                l.rb = 1'b1;
            end
            ST_AY: begin
                l.ya = 1'b1;
                l.rb = 1'b1;
            end
            ST_BG: begin
                l.ra = 1'b1;
                l.gb = 1'b1;
            end
            ST_BY: begin
                l.ra = 1'b1;
                l.yb = 1'b1;
            end
            default: begin
                l.ra = 1'b1;
                l.rb = 1'b1;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/intersection_phase_scheduler_if.sv
// Sensor/request inputs and lamp/status outputs of the intersection scheduler.
interface intersection_phase_scheduler_if;

    logic       Ta;
    logic       Tb;
    logic       ped_req;
    logic       Ra;
    logic       Ya;
    logic       Ga;
    logic       Rb;
    logic       Yb;
    logic       Gb;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    modport master (
        output Ta, Tb, ped_req,
        input  Ra, Ya, Ga, Rb, Yb, Gb, walk, ped_ack, phase
    );

    modport slave (
        input  Ta, Tb, ped_req,
        output Ra, Ya, Ga, Rb, Yb, Gb, walk, ped_ack, phase
    );

endinterface

// File: rtl/phase_timer.sv
// Phase timer: clears on a state change, otherwise counts up and holds at 255.
module phase_timer
    import traffic_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-street traffic phase scheduler with optional pedestrian walk phase.
// Define INTERSECTION_PED_EN to build the pedestrian logic in.
//
// state | meaning
// AG    | street A green, B red
// AY    | street A yellow, B red
// AR1   | all red after A, B green due next
// BG    | street B green, A red
// BY    | street B yellow, A red
// AR2   | all red after B, A green due next
// PW    | pedestrian walk, all red
// BAD   | illegal code, recovers to AR1
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = DEF_MIN_GREEN,
    parameter int MAX_GREEN = DEF_MAX_GREEN,
    parameter int YELLOW_T  = DEF_YELLOW_T,
    parameter int ALLRED_T  = DEF_ALLRED_T,
    parameter int WALK_T    = DEF_WALK_T
) (
    input  logic                         clk,
    input  logic                         reset,
    intersection_phase_scheduler_if.slave bus
);

    localparam logic [CNT_W-1:0] MIN_M1    = 8'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_M1    = 8'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_M1 = 8'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_M1 = 8'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_M1   = 8'(WALK_T - 1);

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clear;
    dir_t             next_dir;
    logic             ped_pend;
    logic             pw_entry;
    logic             a_wait;
    logic             b_wait;
    logic             a_go;
    logic             b_go;
    lamps_t           lamps_q;
    logic             walk_q;
    logic             ack_q;

    phase_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .cnt   (cnt)
    );

    assign cnt_clear = (nxt != state);
    assign pw_entry  = (nxt == ST_PW) && (state != ST_PW);

`ifdef INTERSECTION_PED_EN
    localparam bit PED_EN = 1'b1;

    // A request arriving on the cycle walk starts still counts, earning another walk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_pend <= 1'b0;
        end else begin
            ped_pend <= bus.ped_req | (ped_pend & ~pw_entry);
        end
    end
`else
    localparam bit PED_EN = 1'b0;

    logic unused_ped_req;
    assign ped_pend       = 1'b0;
    assign unused_ped_req = bus.ped_req;
`endif

    assign a_wait = bus.Tb | ped_pend;
    assign b_wait = bus.Ta | ped_pend;
    assign a_go   = ((cnt >= MIN_M1) && !bus.Ta && a_wait) || ((cnt >= MAX_M1) && a_wait);
    assign b_go   = ((cnt >= MIN_M1) && !bus.Tb && b_wait) || ((cnt >= MAX_M1) && b_wait);

    always_comb begin
        nxt = state;
        case (state)
            ST_AG:  if (a_go) nxt = ST_AY;
            ST_AY:  if (cnt == YELLOW_M1) nxt = ST_AR1;
            ST_AR1: if (cnt == ALLRED_M1) nxt = ped_pend ? ST_PW : ST_BG;
            ST_BG:  if (b_go) nxt = ST_BY;
            ST_BY:  if (cnt == YELLOW_M1) nxt = ST_AR2;
            ST_AR2: if (cnt == ALLRED_M1) nxt = ped_pend ? ST_PW : ST_AG;
            ST_PW: begin
                if (!PED_EN) begin
                    nxt = ST_AR1;
                end else if (cnt == WALK_M1) begin
                    nxt = (next_dir == DIR_B) ? ST_BG : ST_AG;
                end
            end
            default: nxt = ST_AR1;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_AG;
            next_dir <= DIR_B;
            lamps_q  <= lamps_for(ST_AG);
            walk_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != state) begin
                if (nxt == ST_AR1) begin
                    next_dir <= DIR_B;
                end else if (nxt == ST_AR2) begin
                    next_dir <= DIR_A;
                end
            end
            lamps_q <= lamps_for(nxt);
            walk_q  <= PED_EN && (nxt == ST_PW);
            ack_q   <= PED_EN && pw_entry;
        end
    end

    assign bus.Ra      = lamps_q.ra;
    assign bus.Ya      = lamps_q.ya;
    assign bus.Ga      = lamps_q.ga;
    assign bus.Rb      = lamps_q.rb;
    assign bus.Yb      = lamps_q.yb;
    assign bus.Gb      = lamps_q.gb;
    assign bus.walk    = walk_q;
    assign bus.ped_ack = ack_q;
    assign bus.phase   = state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed vector bench for intersection_phase_scheduler at default timing.
module tb_intersection_phase_scheduler;

    localparam logic [2:0] P_AG  = 3'd0;
    localparam logic [2:0] P_AY  = 3'd1;
    localparam logic [2:0] P_AR1 = 3'd2;
    localparam logic [2:0] P_BG  = 3'd3;
    localparam logic [2:0] P_BY  = 3'd4;
    localparam logic [2:0] P_AR2 = 3'd5;
    localparam logic [2:0] P_PW  = 3'd6;

    typedef struct {
        string      nm;
        bit         rst;
        bit         ta;
        bit         tb;
        bit         ped;
        int         adv;
        logic [2:0] ph;
        bit         w;
        bit         a;
    } vec_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    vec_t vt[$];

    intersection_phase_scheduler_if bus ();

    intersection_phase_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {Ra,Ya,Ga,Rb,Yb,Gb} expected for each phase
    function automatic logic [5:0] exp_lamps(logic [2:0] p);
        case (p)
            P_AG:    return 6'b001_100;
            P_AY:    return 6'b010_100;
            P_BG:    return 6'b100_001;
            P_BY:    return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string nm, input bit rst, input bit ta, input bit tb,
                       input bit ped, input int adv, input logic [2:0] ph,
                       input bit w, input bit a);
        vec_t v;
        v.nm = nm; v.rst = rst; v.ta = ta; v.tb = tb; v.ped = ped;
        v.adv = adv; v.ph = ph; v.w = w; v.a = a;
        vt.push_back(v);
    endtask

    task automatic check(input string nm, input logic [2:0] ph, input bit w, input bit a);
        logic [5:0] got;
        got = {bus.Ra, bus.Ya, bus.Ga, bus.Rb, bus.Yb, bus.Gb};
        total++;
        if (bus.phase !== ph) begin
            bad++;
            $display("FAIL %s phase got=%0d want=%0d", nm, bus.phase, ph);
        end
        total++;
        if (got !== exp_lamps(ph)) begin
            bad++;
            $display("FAIL %s lamps got=%b want=%b", nm, got, exp_lamps(ph));
        end
        total++;
        if (bus.walk !== w) begin
            bad++;
            $display("FAIL %s walk got=%b want=%b", nm, bus.walk, w);
        end
        total++;
        if (bus.ped_ack !== a) begin
            bad++;
            $display("FAIL %s ped_ack got=%b want=%b", nm, bus.ped_ack, a);
        end
    endtask

    task automatic check_lamp_rules();
        bit ok;
        ok = ($countones({bus.Ra, bus.Ya, bus.Ga}) == 1) &&
             ($countones({bus.Rb, bus.Yb, bus.Gb}) == 1) &&
             !(bus.Ga && (bus.Yb || bus.Gb)) &&
             !(bus.Gb && (bus.Ya || bus.Ga));
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL lamp_rules got=%b want=one lamp per street, no conflict",
                     {bus.Ra, bus.Ya, bus.Ga, bus.Rb, bus.Yb, bus.Gb});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        bus.Ta      = 1'b0;
        bus.Tb      = 1'b0;
        bus.ped_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // B traffic only: AY at 4, AR1 at 7, BG at 9, then B holds
        add("rst_state",     1, 0, 1, 0, 0,  P_AG,  0, 0);
        add("ag_min_hold",   0, 0, 1, 0, 3,  P_AG,  0, 0);
        add("ay_at_4",       0, 0, 1, 0, 1,  P_AY,  0, 0);
        add("ay_at_6",       0, 0, 1, 0, 2,  P_AY,  0, 0);
        add("ar1_at_7",      0, 0, 1, 0, 1,  P_AR1, 0, 0);
        add("ar1_at_8",      0, 0, 1, 0, 1,  P_AR1, 0, 0);
        add("bg_at_9",       0, 0, 1, 0, 1,  P_BG,  0, 0);
        add("bg_hold",       0, 0, 1, 0, 40, P_BG,  0, 0);
        // both streets busy: long-green B yields at once, then 16-cycle greens
        add("by_max",        0, 1, 1, 0, 1,  P_BY,  0, 0);
        add("ar2",           0, 1, 1, 0, 3,  P_AR2, 0, 0);
        add("ag_after_ar2",  0, 1, 1, 0, 2,  P_AG,  0, 0);
        add("ag_15",         0, 1, 1, 0, 15, P_AG,  0, 0);
        add("ay_at_16",      0, 1, 1, 0, 1,  P_AY,  0, 0);
        add("bg_after_clr",  0, 1, 1, 0, 5,  P_BG,  0, 0);
        add("bg_15",         0, 1, 1, 0, 15, P_BG,  0, 0);
        add("by_at_16",      0, 1, 1, 0, 1,  P_BY,  0, 0);
        // A traffic only holds AG indefinitely
        add("rst_a_only",    1, 1, 0, 0, 0,  P_AG,  0, 0);
        add("ag_100",        0, 1, 0, 0, 100, P_AG, 0, 0);
        add("ag_idle",       0, 0, 0, 0, 5,  P_AG,  0, 0);
        add("ay_late_tb",    0, 0, 1, 0, 1,  P_AY,  0, 0);
        add("rst_max",       1, 1, 0, 0, 0,  P_AG,  0, 0);
        add("ag_20",         0, 1, 0, 0, 20, P_AG,  0, 0);
        add("ay_tb_past_max",0, 1, 1, 0, 1,  P_AY,  0, 0);
`ifdef INTERSECTION_PED_EN
        // pulse in AG, walk after AR1, then BG
        add("p_rst",         1, 0, 0, 0, 0,  P_AG,  0, 0);
        add("p_pulse",       0, 0, 0, 1, 1,  P_AG,  0, 0);
        add("p_ag3",         0, 0, 0, 0, 2,  P_AG,  0, 0);
        add("p_ay4",         0, 0, 0, 0, 1,  P_AY,  0, 0);
        add("p_ar1_7",       0, 0, 0, 0, 3,  P_AR1, 0, 0);
        add("p_ar1_8",       0, 0, 0, 0, 1,  P_AR1, 0, 0);
        add("p_pw_first",    0, 0, 0, 0, 1,  P_PW,  1, 1);
        add("p_pw_second",   0, 0, 0, 0, 1,  P_PW,  1, 0);
        add("p_pw_last",     0, 0, 0, 0, 4,  P_PW,  1, 0);
        add("p_bg",          0, 0, 0, 0, 1,  P_BG,  0, 0);
        add("p_bg_idle",     0, 0, 0, 0, 3,  P_BG,  0, 0);
        // held request through the walk earns a second walk, then A green
        add("h_by",          0, 0, 0, 1, 2,  P_BY,  0, 0);
        add("h_ar2",         0, 0, 0, 1, 3,  P_AR2, 0, 0);
        add("h_pw",          0, 0, 0, 1, 2,  P_PW,  1, 1);
        add("h_pw_held",     0, 0, 0, 1, 1,  P_PW,  1, 0);
        add("h_ag",          0, 0, 0, 0, 5,  P_AG,  0, 0);
        add("h_ag3",         0, 0, 0, 0, 3,  P_AG,  0, 0);
        add("h_ay",          0, 0, 0, 0, 1,  P_AY,  0, 0);
        add("h_ar1",         0, 0, 0, 0, 3,  P_AR1, 0, 0);
        add("h_pw2",         0, 0, 0, 0, 2,  P_PW,  1, 1);
        add("h_pw2_next",    0, 0, 0, 0, 1,  P_PW,  1, 0);
        add("h_bg",          0, 0, 0, 0, 5,  P_BG,  0, 0);
        add("h_bg_quiet",    0, 0, 0, 0, 20, P_BG,  0, 0);
`else
        add("ped_ignored",   1, 1, 0, 1, 30, P_AG,  0, 0);
        add("ped_ign_idle",  0, 0, 0, 1, 30, P_AG,  0, 0);
`endif

        foreach (vt[i]) begin
            if (vt[i].rst) do_reset();
            bus.Ta      = vt[i].ta;
            bus.Tb      = vt[i].tb;
            bus.ped_req = vt[i].ped;
            for (int c = 0; c < vt[i].adv; c++) begin
                tick();
                check_lamp_rules();
            end
            check(vt[i].nm, vt[i].ph, vt[i].w, vt[i].a);
        end

        // asynchronous reset during BY, with a pending request to be discarded
        do_reset();
        bus.Ta      = 1'b0;
        bus.Tb      = 1'b1;
        bus.ped_req = 1'b0;
        repeat (9) tick();
        check("seq_bg", P_BG, 0, 0);
        bus.Ta = 1'b1;
        bus.Tb = 1'b0;
        repeat (4) tick();
        check("seq_by", P_BY, 0, 0);
        bus.ped_req = 1'b1;
        tick();
        bus.ped_req = 1'b0;
        check("seq_by_ped", P_BY, 0, 0);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst", P_AG, 0, 0);
        #1;
        reset  = 1'b0;
        bus.Ta = 1'b0;
        bus.Tb = 1'b0;
        repeat (10) tick();
        check("rst_discard", P_AG, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
